// File: rtl/reg_write_arbiter.sv
// Arbitrates host and sequencer writes onto the shared 16-byte sound register bank,
// producing one strobe pulse per write and guarding 4-register banks with per-bank locks.
module reg_write_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int LOCK_TIMEOUT  = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_valid,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ready,
  input  logic       seq_valid,
  input  logic [3:0] seq_addr,
  input  logic [7:0] seq_data,
  output logic       seq_ready,
  output logic [3:0] out_addr,
  output logic [7:0] out_data,
  output logic       out_strobe,
  output logic       busy,
  output logic [3:0] lock_status,
  output logic [3:0] lock_timeout
);

  typedef enum logic [1:0] {IDLE, ACK, DRIVE, GAP} state_t;

  localparam int TW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int PMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW   = (PMAX > 1) ? $clog2(PMAX + 1) : 1;

  state_t          state;
  logic [CW-1:0]   phase_cnt;
  logic            last_grant;
  logic [3:0]      locked;
  logic [3:0]      owner;
  logic [TW-1:0]   timer [4];

  logic            host_elig, seq_elig, pick_seq, grant;
  logic [3:0]      win_addr;
  logic [7:0]      win_data;
  logic [3:0]      locked_n, owner_n, timeout_n;
  logic [TW-1:0]   timer_n [4];

  // Owner value 1 means sequencer, 0 means host; a port may always write its own bank.
  assign host_elig = host_valid && (!locked[host_addr[3:2]] || !owner[host_addr[3:2]]);
  assign seq_elig  = seq_valid  && (!locked[seq_addr[3:2]]  ||  owner[seq_addr[3:2]]);
  assign pick_seq  = seq_elig && (!host_elig || !last_grant);
  assign grant     = (state == IDLE) && (host_elig || seq_elig);
  assign win_addr  = pick_seq ? seq_addr : host_addr;
  assign win_data  = pick_seq ? seq_data : host_data;
  assign lock_status = locked;

  // A grant's lock action takes priority over the countdown, so a reload masks expiry.
  always_comb begin
    locked_n  = locked;
    owner_n   = owner;
    timeout_n = '0;
    for (int b = 0; b < 4; b++) begin
      timer_n[b] = timer[b];
      if (grant && (win_addr[3:2] == 2'(b))) begin
        case (win_addr[1:0])
          2'd0: begin
            locked_n[b] = 1'b1;
            owner_n[b]  = pick_seq;
            timer_n[b]  = TW'(LOCK_TIMEOUT);
          end
          2'd3: begin
            if (locked[b]) begin
              locked_n[b] = 1'b0;
              timer_n[b]  = '0;
            end
          end
          default: begin
            if (locked[b]) timer_n[b] = TW'(LOCK_TIMEOUT);
          end
        endcase
      end else if (locked[b]) begin
        if (timer[b] == TW'(1) || timer[b] == '0) begin
          locked_n[b]  = 1'b0;
          timer_n[b]   = '0;
          timeout_n[b] = 1'b1;
        end else begin
          timer_n[b] = timer[b] - TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked       <= '0;
      owner        <= '0;
      lock_timeout <= '0;
      for (int b = 0; b < 4; b++) timer[b] <= '0;
    end else begin
      locked       <= locked_n;
      owner        <= owner_n;
      lock_timeout <= timeout_n;
      for (int b = 0; b < 4; b++) timer[b] <= timer_n[b];
    end
  end

  // Write sequencing: grant, one-cycle ready, strobe high phase, strobe low gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      last_grant <= 1'b1;
      host_ready <= 1'b0;
      seq_ready  <= 1'b0;
      out_strobe <= 1'b0;
      busy       <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      host_ready <= 1'b0;
      seq_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            out_addr   <= win_addr;
            out_data   <= win_data;
            last_grant <= pick_seq;
            host_ready <= !pick_seq;
            seq_ready  <= pick_seq;
            busy       <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          out_strobe <= 1'b1;
          phase_cnt  <= '0;
          state      <= DRIVE;
        end
        DRIVE: begin
          if (phase_cnt == CW'(STROBE_CYCLES - 1)) begin
            out_strobe <= 1'b0;
            phase_cnt  <= '0;
            state      <= GAP;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        GAP: begin
          if (phase_cnt == CW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        default: begin
          out_strobe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter: arbitration, timing, bank locks, timeout, reset.
module tb_reg_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_valid, seq_valid;
  logic [3:0] host_addr, seq_addr;
  logic [7:0] host_data, seq_data;
  logic       host_ready, seq_ready;
  logic [3:0] out_addr;
  logic [7:0] out_data;
  logic       out_strobe, busy;
  logic [3:0] lock_status, lock_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.STROBE_CYCLES(2), .GAP_CYCLES(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .seq_valid(seq_valid), .seq_addr(seq_addr), .seq_data(seq_data), .seq_ready(seq_ready),
    .out_addr(out_addr), .out_data(out_data), .out_strobe(out_strobe), .busy(busy),
    .lock_status(lock_status), .lock_timeout(lock_timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic hv, input logic [3:0] ha, input logic [7:0] hd,
                               input logic sv, input logic [3:0] sa, input logic [7:0] sd);
    host_valid = hv; host_addr = ha; host_data = hd;
    seq_valid  = sv; seq_addr  = sa; seq_data  = sd;
  endtask

  // Waits (bounded) for a ready pulse and checks which port won and what was latched.
  task automatic waitGrant(input string tag, input logic exp_seq, input logic [3:0] exp_addr,
                           output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(host_ready || seq_ready) && waited < 20);
    checkOutput({tag, "_granted"}, 32'(host_ready | seq_ready), 32'd1);
    checkOutput({tag, "_seq_ready"}, 32'(seq_ready), 32'(exp_seq));
    checkOutput({tag, "_host_ready"}, 32'(host_ready), 32'(!exp_seq));
    checkOutput({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int lock_cycles;
    logic early;
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    @(negedge clk);
    doReset();

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_strobe", 32'(out_strobe), 32'd0);
    checkOutput("rst_addr", 32'(out_addr), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_ready", 32'({host_ready, seq_ready}), 32'd0);
    checkOutput("rst_locks", 32'({lock_status, lock_timeout}), 32'd0);

    // Single write: ready, two strobe-high cycles, two low, then idle.
    applyStimulus(1, 4'h7, 8'hA5, 0, 4'h0, 8'h00);
    waitGrant("t1", 0, 4'h7, n);
    checkOutput("t1_latency", 32'(n), 32'd1);
    checkOutput("t1_data", 32'(out_data), 32'hA5);
    checkOutput("t1_busy_ack", 32'(busy), 32'd1);
    checkOutput("t1_strobe_ack", 32'(out_strobe), 32'd0);
    applyStimulus(0, 4'h7, 8'hA5, 0, 4'h0, 8'h00);
    @(negedge clk); checkOutput("t1_strobe_c2", 32'({out_strobe, host_ready}), 32'b10);
    @(negedge clk); checkOutput("t1_strobe_c3", 32'(out_strobe), 32'd1);
    @(negedge clk); checkOutput("t1_strobe_c4", 32'(out_strobe), 32'd0);
    @(negedge clk); checkOutput("t1_strobe_c5", 32'({out_strobe, busy}), 32'b01);
    checkOutput("t1_data_stable", 32'({out_addr, out_data}), 32'h7A5);
    @(negedge clk); checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_nolock", 32'(lock_status), 32'd0);

    // Tie arbitration after reset: host first, then alternate every 6 cycles.
    doReset();
    applyStimulus(1, 4'h1, 8'h11, 1, 4'h9, 8'h22);
    for (int g = 0; g < 4; g++) begin
      waitGrant($sformatf("t2_g%0d", g), g[0], g[0] ? 4'h9 : 4'h1, n);
      checkOutput($sformatf("t2_g%0d_period", g), 32'(n), (g == 0) ? 32'd1 : 32'd6);
      checkOutput($sformatf("t2_g%0d_data", g), 32'(out_data), g[0] ? 32'h22 : 32'h11);
    end
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    repeat (6) @(negedge clk);

    // Bank lock: sequencer holds bank 1 across a 4-register update.
    applyStimulus(0, 4'h0, 8'h00, 1, 4'h4, 8'h40);
    waitGrant("t3_s4", 1, 4'h4, n);
    checkOutput("t3_lock_s4", 32'(lock_status), 32'b0010);
    applyStimulus(1, 4'h5, 8'h55, 1, 4'h5, 8'h41);
    waitGrant("t3_s5", 1, 4'h5, n);
    checkOutput("t3_s5_period", 32'(n), 32'd6);
    applyStimulus(1, 4'h5, 8'h55, 1, 4'h6, 8'h42);
    waitGrant("t3_s6", 1, 4'h6, n);
    checkOutput("t3_lock_s6", 32'(lock_status), 32'b0010);
    applyStimulus(1, 4'h5, 8'h55, 1, 4'h7, 8'h43);
    waitGrant("t3_s7", 1, 4'h7, n);
    checkOutput("t3_unlock_s7", 32'(lock_status), 32'b0000);
    applyStimulus(1, 4'h5, 8'h55, 0, 4'h0, 8'h00);
    waitGrant("t3_h5", 0, 4'h5, n);
    checkOutput("t3_h5_period", 32'(n), 32'd6);
    checkOutput("t3_h5_data", 32'(out_data), 32'h55);
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    repeat (6) @(negedge clk);

    // Lock timeout: abandoned host lock on bank 0 expires after 8 cycles.
    applyStimulus(1, 4'h0, 8'h0A, 0, 4'h0, 8'h00);
    waitGrant("t4_h0", 0, 4'h0, n);
    checkOutput("t4_locked", 32'(lock_status), 32'b0001);
    applyStimulus(0, 4'h0, 8'h00, 1, 4'h1, 8'h1B);
    lock_cycles = 1;
    early = 1'b0;
    while (lock_cycles < 20) begin
      @(negedge clk);
      if (seq_ready) early = 1'b1;
      if (!lock_status[0]) break;
      lock_cycles++;
    end
    checkOutput("t4_lock_cycles", 32'(lock_cycles), 32'd8);
    checkOutput("t4_pulse", 32'(lock_timeout), 32'b0001);
    checkOutput("t4_no_early_grant", 32'(early), 32'd0);
    waitGrant("t4_s1", 1, 4'h1, n);
    checkOutput("t4_s1_wait", 32'(n), 32'd1);
    checkOutput("t4_pulse_done", 32'(lock_timeout), 32'b0000);
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    repeat (6) @(negedge clk);

    // Non-blocking: host reaches bank 3 while the sequencer owns bank 2.
    applyStimulus(0, 4'h0, 8'h00, 1, 4'h8, 8'h80);
    waitGrant("t5_s8", 1, 4'h8, n);
    checkOutput("t5_lock_b2", 32'(lock_status), 32'b0100);
    applyStimulus(1, 4'hC, 8'hC3, 0, 4'h0, 8'h00);
    waitGrant("t5_h12", 0, 4'hC, n);
    checkOutput("t5_h12_period", 32'(n), 32'd6);
    checkOutput("t5_locks", 32'(lock_status), 32'b1100);
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    repeat (20) @(negedge clk);
    checkOutput("t5_expired", 32'(lock_status), 32'b0000);

    // Reset during DRIVE drops everything; host then wins the first tie.
    applyStimulus(1, 4'h4, 8'h66, 0, 4'h0, 8'h00);
    waitGrant("t6_h4", 0, 4'h4, n);
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    @(negedge clk);
    checkOutput("t6_strobe_hi", 32'(out_strobe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_strobe_rst", 32'(out_strobe), 32'd0);
    checkOutput("t6_busy_rst", 32'(busy), 32'd0);
    checkOutput("t6_lock_rst", 32'(lock_status), 32'd0);
    checkOutput("t6_addr_rst", 32'(out_addr), 32'd0);
    applyStimulus(1, 4'h1, 8'h77, 1, 4'h9, 8'h88);
    waitGrant("t6_tie", 0, 4'h1, n);
    checkOutput("t6_tie_latency", 32'(n), 32'd1);
    applyStimulus(0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the 16-byte sound register bank between two write sources: host (serial UART path) and seq (on-chip autoplay sequencer).
- Grants one write at a time and drives a single addr/data/strobe write port in the format the register decoder expects.
  - out_strobe rises once per write and is then held low for a gap, so each write produces exactly one rising edge.
- Per-bank locking stops a 4-register bank update from one source being interleaved with writes from the other source.

Parameters:
- STROBE_CYCLES, 2, cycles out_strobe is held high per write (min 1).
- GAP_CYCLES, 2, cycles out_strobe is held low after each write before the next grant (min 1).
- LOCK_TIMEOUT, 4095, idle cycles after which an abandoned bank lock is force-released (min 1). Counter width is clog2(LOCK_TIMEOUT+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- host_valid  in  1  host write request.
- host_addr  in  4  host register address; [3:2] is bank, [1:0] is register.
- host_data  in  8  host write data.
- host_ready  out  1  host request accepted (1-cycle pulse).
- seq_valid  in  1  sequencer write request.
- seq_addr  in  4  sequencer register address.
- seq_data  in  8  sequencer write data.
- seq_ready  out  1  sequencer request accepted (1-cycle pulse).
- out_addr  out  4  address to register decoder.
- out_data  out  8  data to register decoder.
- out_strobe  out  1  write strobe to decoder (level, edge-detected downstream).
- busy  out  1  high whenever state is not IDLE.
- lock_status  out  4  bit b high while bank b is locked.
- lock_timeout  out  4  1-cycle pulse on bit b when bank b's lock expires.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - state=IDLE.
  - host_ready=seq_ready=out_strobe=busy=0.
  - out_addr=0, out_data=0.
  - All locks clear; lock_timeout=0.
  - last_grant=seq, so host wins the first tie.
- FSM states: IDLE, ACK, DRIVE, GAP.
- IDLE:
  - A port is eligible if its valid=1 and the bank of its addr is unlocked or owned by that port.
  - No eligible port: stay in IDLE.
  - Exactly one eligible port: grant it.
  - Both eligible: grant the port that is not last_grant (round-robin).
  - On grant:
    - Register winner addr/data into out_addr/out_data.
    - Set last_grant to the winner.
    - Apply the lock update.
    - Go to ACK.
- ACK (1 cycle):
  - The winner's ready=1; the other ready=0.
  - Go to DRIVE.
- DRIVE: out_strobe=1 for STROBE_CYCLES cycles, then go to GAP.
- GAP: out_strobe=0 for GAP_CYCLES cycles, then go to IDLE.
- Timing:
  - valid sampled in cycle N → ready in N+1 → out_strobe high in N+2 through N+1+STROBE_CYCLES.
  - Back-to-back write period is 2+STROBE_CYCLES+GAP_CYCLES (6 at defaults).
- Output stability: out_addr/out_data change only on grant and stay stable through ACK, DRIVE and GAP.
- Requester protocol:
  - Hold valid and payload stable until ready.
  - Payload is captured at grant, so a valid drop during ACK does not cancel the write.
- Lock update on grant (per bank b = addr[3:2]):
  - reg 0 written: lock b to the winner; load its timer with LOCK_TIMEOUT.
  - reg 1 or 2 written by the owner: reload the timer.
  - reg 3 written by the owner: clear the lock.
  - reg 1..3 written to an unlocked bank: no lock change.
  - reg 0 rewritten by the owner: relock (timer reload).
- Lock timer:
  - Decrements by 1 each cycle while locked and not reloaded.
  - When it reaches 0: the lock clears and lock_timeout[b] pulses for one cycle.
  - If a reload and expiry fall in the same cycle, the reload wins and there is no pulse.
- Blocked requests: a port whose bank is locked by the other port stays pending and does not block the other port's requests to other banks.
- Reset mid-operation: everything returns to reset values on the next edge; out_strobe drops immediately; the in-flight write is lost.

Test Plan:
1. Single write: host_valid, addr=4'h7, data=8'hA5 from IDLE → host_ready pulse at cycle N+1; out_addr=7, out_data=A5; out_strobe high exactly 2 cycles, low 2 cycles; busy low after 6 cycles.
2. Tie arbitration: host and seq both valid continuously, different unlocked banks → grants alternate host, seq, host, seq; each write separated by ≥2 low cycles of out_strobe.
3. Bank lock:
   - seq writes addr 4 (locks bank 1); host requests addr 5.
   - Host stalls while seq writes 5, 6, 7; lock_status[1] falls after the addr 7 grant.
   - Host's addr 5 write is then granted.
4. Lock timeout (LOCK_TIMEOUT=8): host writes addr 0 then stops → lock_status[0] clears after 8 cycles with a 1-cycle lock_timeout[0] pulse; a blocked seq write to addr 1 then proceeds.
5. Non-blocking: bank 2 locked by seq; host requests addr 12 → granted without waiting on the bank 2 lock.
6. Reset in DRIVE: assert reset while out_strobe=1 → next cycle out_strobe=0, busy=0, lock_status=0, out_addr=0; first post-reset tie goes to host.
